// File: rtl/sr_rr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// sr_rr_arbiter_pkg
//
// Shared definitions for the SR round-robin arbiter slice.
//
// Contents:
//   ARB_STATE_W            width of the arbiter state register
//   ARB_IDLE/GRANT/GAP     FSM state codes (legacy-compatible constants, so
//                          they can be matched against older debug dumps)
//   arb_state_name()       helper that maps a state code to a short label,
//                          handy for status displays in benches and tools
// ----------------------------------------------------------------------------
package sr_rr_arbiter_pkg;

  localparam int ARB_STATE_W = 2;

  localparam logic [ARB_STATE_W-1:0] ARB_IDLE  = 2'b00;
  localparam logic [ARB_STATE_W-1:0] ARB_GRANT = 2'b01;
  localparam logic [ARB_STATE_W-1:0] ARB_GAP   = 2'b10;

  // Short printable label for a state code; unknown codes come back as "ILL".
  function automatic string arb_state_name(input logic [ARB_STATE_W-1:0] s);
    string name;
    case (s)
      ARB_IDLE:  name = "IDLE";
      ARB_GRANT: name = "GRANT";
      ARB_GAP:   name = "GAP";
      default:   name = "ILL";
    endcase
    return name;
  endfunction

endpackage

// File: rtl/sr_rr_arbiter_pend_cell.sv
// ----------------------------------------------------------------------------
// pend_cell
//
// One SR-style pending-request bit. The bit is set by a request level seen at
// a falling clock edge and cleared by the arbiter on the edge that grants this
// requester. Clear has priority over set, so a request that is still high on
// the granting edge does not survive that edge; it re-sets the bit on the
// following edge if it stays high.
//
// Ports:
//   clk_n  input   clock, state changes on the falling edge
//   clr    input   asynchronous, active-high reset (bit goes to 0)
//   s      input   set (request level)
//   r      input   clear (grant of this requester)
//   q      output  pending bit
// ----------------------------------------------------------------------------
module pend_cell (
  input  logic clk_n,
  input  logic clr,
  input  logic s,
  input  logic r,
  output logic q
);

  import sr_rr_arbiter_pkg::*;

  logic pend_d;
  logic pend_q;

  // Clear-over-set: the grant clear must win so the winner's bit drops on the
  // very edge it is served.
  always_comb begin
    pend_d = pend_q;
    if (r) begin
      pend_d = 1'b0;
    end else if (s) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(negedge clk_n or posedge clr) begin
    if (clr) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign q = pend_q;

endmodule

// File: rtl/sr_rr_arbiter.sv
// ----------------------------------------------------------------------------
// sr_rr_arbiter
//
// Round-robin arbiter that shares one resource (for example a bank of set/reset
// status flip-flops) between N requesters. Each request is latched into an
// SR-style pending bit; a three-state FSM (IDLE, GRANT, GAP) hands out a
// one-hot grant, holds it until the owner releases it or a programmable hold
// limit expires, and then leaves exactly one idle gap cycle before the next
// owner can be granted.
//
// Parameters:
//   N       number of requesters (2..8)
//   HOLD_W  width of max_hold and of the hold counter
//   ID_W    width of gnt_id, equal to clog2(N)
//
// Ports:
//   clk_n     input   clock, every state change happens on the falling edge
//   clr       input   asynchronous, active-high reset
//   req       input   request levels, sampled on each falling edge
//   rel       input   release from the current owner (other bits ignored)
//   max_hold  input   maximum grant length minus one, in cycles
//   gnt       output  one-hot grant, all zero when nobody owns the resource
//   gnt_id    output  index of the current or most recent owner
//   busy      output  high while a grant is active
//   tmo       output  one-cycle pulse in the gap after a hold-limit expiry
//   pend      output  pending request bits
//
// Build option:
//   ARB_FIXED_PRIO_EN  when defined, the lowest-index pending requester always
//                      wins (starvation allowed); the rotation pointer still
//                      tracks the last owner for gnt_id. When undefined, the
//                      search starts just after the last owner and wraps.
// ----------------------------------------------------------------------------
module sr_rr_arbiter #(
  parameter int N      = 4,
  parameter int HOLD_W = 4,
  parameter int ID_W   = 2
) (
  input  logic              clk_n,
  input  logic              clr,
  input  logic [N-1:0]      req,
  input  logic [N-1:0]      rel,
  input  logic [HOLD_W-1:0] max_hold,
  output logic [N-1:0]      gnt,
  output logic [ID_W-1:0]   gnt_id,
  output logic              busy,
  output logic              tmo,
  output logic [N-1:0]      pend
);

  import sr_rr_arbiter_pkg::*;

  logic [ARB_STATE_W-1:0] state_d, state_q;
  logic [HOLD_W-1:0]      cnt_d, cnt_q;
  logic [ID_W-1:0]        ptr_d, ptr_q;
  logic                   tmo_d, tmo_q;

  logic [N-1:0]           pend_q;
  logic [N-1:0]           pend_clr;
  logic [ID_W-1:0]        win;
  logic [N-1:0]           win_mask;

  // --------------------------------------------------------------------------
  // Winner selection helpers
  // --------------------------------------------------------------------------

  // Round-robin: first set bit strictly after 'last', wrapping modulo N, so the
  // previous owner is considered only after every other requester.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N-1:0]    p,
                                               input logic [ID_W-1:0] last);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] idx_c;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int off = 1; off <= N; off++) begin
      idx   = (int'(last) + off) % N;
      idx_c = ID_W'(idx);
      if (!found && p[idx_c]) begin
        found = 1'b1;
        pick  = idx_c;
      end
    end
    return pick;
  endfunction

  // Fixed priority: lowest set index wins. Scanning downward lets the lowest
  // index be the last assignment.
  function automatic logic [ID_W-1:0] fixed_pick(input logic [N-1:0] p);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] idx_c;
    pick = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx_c = ID_W'(i);
      if (p[idx_c]) begin
        pick = idx_c;
      end
    end
    return pick;
  endfunction

  // --------------------------------------------------------------------------
  // Pending bits, one SR cell per requester
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N; i++) begin : g_pend
    pend_cell u_pend_cell (
      .clk_n (clk_n),
      .clr   (clr),
      .s     (req[i]),
      .r     (pend_clr[i]),
      .q     (pend_q[i])
    );
  end

  // --------------------------------------------------------------------------
  // Winner of the current pending set (only used when a grant is issued)
  // --------------------------------------------------------------------------
  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    win = fixed_pick(pend_q);
`else
    win = rr_pick(pend_q, ptr_q);
`endif
    win_mask      = '0;
    win_mask[win] = 1'b1;
  end

  // --------------------------------------------------------------------------
  // FSM next state
  //
  // GAP shares the selection logic with IDLE: the edge that ends the gap can
  // grant straight away, which keeps consecutive owners exactly one cycle
  // apart. tmo defaults low, so it is high only in the gap that follows an
  // expiry.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    tmo_d    = 1'b0;
    pend_clr = '0;

    case (state_q)
      ARB_IDLE, ARB_GAP: begin
        if (|pend_q) begin
          state_d  = ARB_GRANT;
          ptr_d    = win;
          cnt_d    = '0;
          pend_clr = win_mask;
        end else begin
          state_d = ARB_IDLE;
        end
      end

      ARB_GRANT: begin
        // Release outranks expiry, so a simultaneous release never reports tmo.
        if (rel[ptr_q]) begin
          state_d = ARB_GAP;
        end else if (cnt_q == max_hold) begin
          state_d = ARB_GAP;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(negedge clk_n or posedge clr) begin
    if (clr) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      ptr_q   <= ID_W'(N - 1);
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      tmo_q   <= tmo_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  //
  // The grant is decoded from the state and the pointer, so it is one-hot by
  // construction and falls the instant clr resets the state register.
  // --------------------------------------------------------------------------
  always_comb begin
    gnt = '0;
    if (state_q == ARB_GRANT) begin
      gnt[ptr_q] = 1'b1;
    end
  end

  assign gnt_id = ptr_q;
  assign busy   = (state_q == ARB_GRANT);
  assign tmo    = tmo_q;
  assign pend   = pend_q;

endmodule

// File: tb/tb_sr_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sr_rr_arbiter
//
// Self-checking bench for sr_rr_arbiter. A behavioural reference model tracks
// the owner, the cycles it has held the grant, the last owner and the pending
// set as plain integers, and every falling edge is followed by a comparison of
// all outputs against it. Directed scenarios check grant order, release vs
// expiry, asynchronous reset and the zero hold limit; a randomized run follows.
// Build with ARB_FIXED_PRIO_EN defined to exercise the fixed-priority variant.
// ----------------------------------------------------------------------------
module tb_sr_rr_arbiter;

  localparam int N      = 4;
  localparam int HOLD_W = 4;
  localparam int ID_W   = 2;

  logic              clk_n;
  logic              clr;
  logic [N-1:0]      req;
  logic [N-1:0]      rel;
  logic [HOLD_W-1:0] max_hold;
  logic [N-1:0]      gnt;
  logic [ID_W-1:0]   gnt_id;
  logic              busy;
  logic              tmo;
  logic [N-1:0]      pend;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int           mOwner;   // -1 when nobody holds the grant
  int           mLast;    // most recent owner
  int           mHeld;    // cycles of the current grant already completed
  logic         mTmo;
  logic [N-1:0] mPend;

  int   grantOrder[$];
  logic prevBusy;

  sr_rr_arbiter #(
    .N      (N),
    .HOLD_W (HOLD_W),
    .ID_W   (ID_W)
  ) dut (
    .clk_n    (clk_n),
    .clr      (clr),
    .req      (req),
    .rel      (rel),
    .max_hold (max_hold),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .busy     (busy),
    .tmo      (tmo),
    .pend     (pend)
  );

  initial clk_n = 1'b1;
  always #5 clk_n = ~clk_n;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mOwner = -1;
    mLast  = N - 1;
    mHeld  = 0;
    mTmo   = 1'b0;
    mPend  = '0;
  endtask

  function automatic int pickWinner();
    int w;
    w = -1;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) begin
      if (w < 0 && mPend[i]) w = i;
    end
`else
    for (int k = 1; k <= N; k++) begin
      if (w < 0 && mPend[(mLast + k) % N]) w = (mLast + k) % N;
    end
`endif
    return w;
  endfunction

  // One falling edge of the arbiter, described by its rules: an owner either
  // releases, runs out of its max_hold+1 cycles, or keeps going; without an
  // owner the next pending requester is served. Requests latch after the
  // winner's bit is cleared, except that the clear wins for the winner.
  task automatic modelStep(input logic [N-1:0] r, input logic [N-1:0] rl,
                           input logic [HOLD_W-1:0] mh);
    logic [N-1:0] clearMask;
    int w;
    clearMask = '0;
    mTmo      = 1'b0;
    if (mOwner >= 0) begin
      if (rl[mOwner]) begin
        mOwner = -1;
      end else if (mHeld == int'(mh)) begin
        mOwner = -1;
        mTmo   = 1'b1;
      end else begin
        mHeld++;
      end
    end else if (mPend != '0) begin
      w            = pickWinner();
      mOwner       = w;
      mLast        = w;
      mHeld        = 0;
      clearMask[w] = 1'b1;
    end
    mPend = (mPend | r) & ~clearMask;
  endtask

  task automatic checkAll(input string pfx);
    logic [N-1:0] expGnt;
    expGnt = '0;
    if (mOwner >= 0) expGnt[mOwner] = 1'b1;
    checkOutput({pfx, "_gnt"},    32'(gnt),    32'(expGnt));
    checkOutput({pfx, "_gnt_id"}, 32'(gnt_id), 32'(mLast));
    checkOutput({pfx, "_busy"},   32'(busy),   32'(mOwner >= 0));
    checkOutput({pfx, "_tmo"},    32'(tmo),    32'(mTmo));
    checkOutput({pfx, "_pend"},   32'(pend),   32'(mPend));
  endtask

  // Inputs change half a cycle before the active falling edge; outputs are
  // compared 1 time unit after it.
  task automatic applyStimulus(input string pfx, input logic [N-1:0] r,
                               input logic [N-1:0] rl, input logic [HOLD_W-1:0] mh);
    @(posedge clk_n);
    req      = r;
    rel      = rl;
    max_hold = mh;
    @(negedge clk_n);
    modelStep(r, rl, mh);
    #1;
    checkAll(pfx);
    if (busy === 1'b1 && prevBusy !== 1'b1) grantOrder.push_back(int'(gnt_id));
    prevBusy = busy;
  endtask

  // clr rises mid-cycle; the outputs must fall without any clock edge.
  task automatic doReset(input string pfx);
    @(posedge clk_n);
    clr = 1'b1;
    req = '0;
    rel = '0;
    #1;
    modelReset();
    checkAll(pfx);
    @(posedge clk_n);
    clr      = 1'b0;
    prevBusy = 1'b0;
    grantOrder.delete();
  endtask

  task automatic checkOrder(input string tag, input int expected[$]);
    checkOutput({tag, "_count"}, 32'(grantOrder.size()), 32'(expected.size()));
    for (int i = 0; i < expected.size(); i++) begin
      checkOutput(tag, (i < grantOrder.size()) ? 32'(grantOrder[i]) : 32'hFF,
                  32'(expected[i]));
    end
  endtask

  initial begin
    logic [N-1:0]      r;
    logic [N-1:0]      rl;
    logic [N-1:0]      ownerMask;
    logic [HOLD_W-1:0] mh;
    int                expOrder[$];

    clr      = 1'b1;
    req      = '0;
    rel      = '0;
    max_hold = '0;
    prevBusy = 1'b0;
    modelReset();
    #1;
    checkAll("reset");

    // Single request, no release: 4-cycle grant then a tmo gap
    $display("[TB] single request, hold limit expiry");
    doReset("t1_rst");
    applyStimulus("t1", 4'b0001, '0, 4'd3);
    repeat (7) applyStimulus("t1", '0, '0, 4'd3);
    expOrder = '{0};
    checkOrder("t1_order", expOrder);

    // All requesting, owner releases in its 2nd cycle
    $display("[TB] all requesting, release in second cycle");
    doReset("t2_rst");
    repeat (15) begin
      rl = '0;
      if (mOwner >= 0 && mHeld == 1) rl[mOwner] = 1'b1;
      applyStimulus("t2", 4'b1111, rl, 4'd7);
    end
`ifdef ARB_FIXED_PRIO_EN
    expOrder = '{0, 0, 0, 0, 0};
`else
    expOrder = '{0, 1, 2, 3, 0};
`endif
    checkOrder("t2_order", expOrder);

    // Owner 2: release and expiry on the same edge; non-owner release ignored
    $display("[TB] release coincides with expiry");
    doReset("t3_rst");
    applyStimulus("t3", 4'b0100, '0,      4'd1);
    applyStimulus("t3", '0,      '0,      4'd1);
    applyStimulus("t3", '0,      4'b1000, 4'd1);
    applyStimulus("t3", '0,      4'b0100, 4'd1);
    applyStimulus("t3", '0,      '0,      4'd1);
    applyStimulus("t3", '0,      '0,      4'd1);

    // Asynchronous reset mid-grant, then the pointer restarts from N-1
    $display("[TB] asynchronous reset during a grant");
    doReset("t4_pre");
    repeat (4) applyStimulus("t4", 4'b1111, '0, 4'd7);
    checkOutput("t4_busy_before", 32'(busy), 32'd1);
    doReset("t4_async");
    applyStimulus("t4", 4'b0010, '0, 4'd7);
    repeat (3) applyStimulus("t4", '0, '0, 4'd7);
    expOrder = '{1};
    checkOrder("t4_order", expOrder);

    // Owner keeps requesting while another requester pulses once
    $display("[TB] owner re-requests, rotation to other requester");
    doReset("t5_rst");
    applyStimulus("t5", 4'b0010, '0, 4'd2);
    applyStimulus("t5", 4'b0010, '0, 4'd2);
    applyStimulus("t5", 4'b1010, '0, 4'd2);
    repeat (9) applyStimulus("t5", 4'b0010, '0, 4'd2);
`ifdef ARB_FIXED_PRIO_EN
    expOrder = '{1, 1, 1};
`else
    expOrder = '{1, 3, 1};
`endif
    checkOrder("t5_order", expOrder);

    // Two requesters held, one-cycle grants (max_hold = 0)
    $display("[TB] two requesters held, zero hold limit");
    doReset("t6_rst");
    repeat (8) applyStimulus("t6", 4'b1010, '0, 4'd0);
`ifdef ARB_FIXED_PRIO_EN
    expOrder = '{1, 1, 1, 1};
`else
    expOrder = '{1, 3, 1, 3};
`endif
    checkOrder("t6_order", expOrder);

    // Randomized traffic; max_hold only changes while nobody owns the grant
    $display("[TB] randomized traffic");
    doReset("rnd_rst");
    mh = 4'd2;
    repeat (400) begin
      r         = N'($urandom) & N'($urandom);
      ownerMask = '0;
      if (mOwner >= 0) ownerMask[mOwner] = 1'b1;
      rl = N'($urandom) & ~ownerMask;
      if (mOwner >= 0 && $urandom_range(0, 3) == 0) rl = rl | ownerMask;
      if (mOwner < 0) mh = HOLD_W'($urandom_range(0, 3));
      applyStimulus("rnd", r, rl, mh);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sr_rr_arbiter.md
Name: sr_rr_arbiter

Overview:
- Round-robin arbiter sharing one resource between N requesters, such as a bank of set/reset status flip-flops driven by one owner at a time.
- Each requester's request is captured in an SR-style pending bit.
- A 3-state FSM issues one-hot grants, holds each grant until the owner releases it or a programmable hold limit expires, then inserts one idle gap cycle.
- Sits between the requesting blocks and the shared SR flip-flop datapath.

Parameters:
- N, 4, number of requesters (2..8)
- HOLD_W, 4, width of the hold-limit input and the hold counter
- ID_W, 2, width of gnt_id; must equal clog2(N)

Ports:
- clk_n  input  1  clock; all state changes on the falling edge
- clr  input  1  asynchronous, active-high reset
- req  input  N  request levels; sampled on each falling edge
- rel  input  N  release from the current owner; bits of non-owners are ignored
- max_hold  input  HOLD_W  maximum grant length minus one, in cycles
- gnt  output  N  one-hot grant; all zero when no grant
- gnt_id  output  ID_W  index of the current or last owner
- busy  output  1  high while in GRANT
- tmo  output  1  one-cycle pulse when a grant ended by hold-limit expiry
- pend  output  N  pending request bits (debug/status)

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Clock: clk_n, falling-edge active. Reset: clr, asynchronous, active-high.
- Reset values, applied immediately at any time:
  - gnt=0, gnt_id=N-1, busy=0, tmo=0, pend=0
  - state=IDLE, hold counter cnt=0, round-robin pointer ptr=N-1
- Reset mid-grant drops gnt at once; the interrupted owner receives no tmo.
- Pending bits, one per requester:
  - set when req[i]=1 at an edge
  - cleared at the edge that grants i
  - clear beats set on the same edge
  - a req held high re-sets pend[i] on the next edge
- FSM states: IDLE=2'b00, GRANT=2'b01, GAP=2'b10.
- IDLE:
  - if any pend bit is set, select the winner by searching from ptr+1 upward with wrap modulo N
  - on the same edge: gnt[w]=1, gnt_id=w, ptr=w, cnt=0, busy=1, clear pend[w], go to GRANT
  - otherwise stay in IDLE
- GRANT, evaluated at each edge:
  - if rel[gnt_id]=1: go to GAP, tmo=0
  - else if cnt==max_hold: go to GAP, tmo=1
  - else cnt=cnt+1
  - leaving GRANT forces gnt=0 and busy=0
  - rel and expiry on the same edge: rel wins, tmo=0
- GAP:
  - exactly one cycle, gnt=0
  - tmo is high only during this cycle
  - next edge goes to IDLE, clears tmo, and may immediately grant again
- Latency:
  - req sampled at edge k sets pend at edge k
  - the earliest grant is at edge k+1
  - back-to-back owners are separated by exactly 1 gap cycle
- Grant length is max_hold+1 cycles at most; max_hold=0 gives 1-cycle grants.
- cnt is HOLD_W bits, never wraps, and is compared for equality only.
- max_hold is sampled every cycle; the team requires it to be static during a grant.
- A request from the current owner during GRANT sets its pend bit; that owner is served again only after the others, by rotation.
- gnt is never multi-hot.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN
- Defined: the winner is the lowest-index set pend bit; ptr is still updated for gnt_id but ignored in selection. Starvation is permitted.
- Undefined: round-robin as specified above.

Decomposition:
- Shared include file arb_defs.vh holds the state codes ARB_IDLE, ARB_GRANT, ARB_GAP.
- Sub-module pend_cell: one SR-style pending bit with ports clk_n, clr, s (req), r (grant clear). The clear-over-set priority is local to this cell.
- Winner selection is a combinational function inside sr_rr_arbiter.

Test Plan:
- Reset then req=4'b0001 for one cycle, max_hold=3:
  - pend[0] set at edge 1, gnt=4'b0001 at edge 2
  - no rel, so gnt is held 4 cycles, then tmo=1 for 1 cycle, then gnt=0
- All req=4'b1111 held high, rel pulsed at each grant's 2nd cycle:
  - grant order 0,1,2,3,0
  - each grant lasts 2 cycles, followed by 1 GAP cycle
- Owner 2 with rel=4'b0100 and cnt==max_hold on the same edge:
  - GAP entered, tmo=0
  - rel=4'b1000 from a non-owner during the grant has no effect
- clr asserted mid-grant at half-cycle offset:
  - gnt, busy, and pend go to 0 immediately without a clock edge
  - after clr drops, req=4'b0010 is granted first as index 1, because ptr was reset to 3
- req[1] held high while 1 is granted, req[3] pulsed once:
  - next grant goes to 3, then to 1 again
- With ARB_FIXED_PRIO_EN defined, req=4'b1010 held:
  - index 1 wins repeatedly and index 3 is never granted
